// File: rtl/tlul_dev_adapter.sv
// Device-side TL-UL responder: bridges one crossbar device port onto a req/gnt + rvalid peripheral bus.
// Optional macro TLUL_DEV_ERRCHK_EN adds address/size/mask legality checks answered locally with d_error.
package tlul_dev_pkg;

   localparam logic [2:0] OP_PUT_FULL    = 3'd0;
   localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] OP_GET         = 3'd4;
   localparam logic [2:0] OP_ACK         = 3'd0;
   localparam logic [2:0] OP_ACK_DATA    = 3'd1;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module tlul_dev_adapter
   import tlul_dev_pkg::*;
#(
   parameter int AW          = 32,
   parameter int Outstanding = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  tl_h2d_t       tl_i,
   output tl_d2h_t       tl_o,
   output logic          req_o,
   input  logic          gnt_i,
   output logic          we_o,
   output logic [AW-1:0] addr_o,
   output logic [31:0]   wdata_o,
   output logic [3:0]    be_o,
   input  logic          rvalid_i,
   input  logic [31:0]   rdata_i,
   input  logic          err_i
);

   localparam int PW = (Outstanding > 1) ? $clog2(Outstanding) : 1;
   localparam int CW = $clog2(Outstanding + 1);
   localparam logic [CW-1:0] DEPTH = CW'(Outstanding);
   localparam logic [PW-1:0] LAST  = PW'(Outstanding - 1);

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // Completion buffer, one slot per accepted A beat, drained strictly in A order.
   logic        is_read_q   [Outstanding];
   logic [1:0]  size_q      [Outstanding];
   logic [7:0]  source_q    [Outstanding];
   logic        local_err_q [Outstanding];
   logic        done_q      [Outstanding];
   logic [31:0] data_q      [Outstanding];
   logic        err_q       [Outstanding];

   logic [PW-1:0] wr_ptr, rd_ptr, pend_idx, scan_idx;
   logic [CW-1:0] count;
   logic          pend_found;
   logic          a_local_err, a_is_write, avail, a_ready, push, pop, complete;
   logic          d_valid, head_err;
   logic          unused_tl;

   assign a_is_write = (tl_i.a_opcode == OP_PUT_FULL) || (tl_i.a_opcode == OP_PUT_PARTIAL);

`ifdef TLUL_DEV_ERRCHK_EN
   logic [3:0] lanes;
   always_comb begin
      case (tl_i.a_size)
         2'd0:    lanes = 4'b0001 << tl_i.a_address[1:0];
         2'd1:    lanes = 4'b0011 << {tl_i.a_address[1], 1'b0};
         default: lanes = 4'b1111;
      endcase
      a_local_err = !(a_is_write || tl_i.a_opcode == OP_GET)
                 || (tl_i.a_address[1:0] != 2'b00)
                 || (tl_i.a_opcode == OP_PUT_FULL && tl_i.a_mask != 4'hF)
                 || (tl_i.a_size == 2'd3)
                 || ((tl_i.a_mask & ~lanes) != 4'h0);
   end
`else
   assign a_local_err = !(a_is_write || tl_i.a_opcode == OP_GET);
`endif

   // a_ready looks only at buffer occupancy and gnt_i, never at d_ready.
   assign avail    = !rst_i && (count < DEPTH);
   assign req_o    = tl_i.a_valid && avail && !a_local_err;
   assign a_ready  = avail && (a_local_err || gnt_i);
   assign push     = tl_i.a_valid && a_ready;
   assign d_valid  = !rst_i && (count != '0) && done_q[rd_ptr];
   assign pop      = d_valid && tl_i.d_ready;
   assign complete = rvalid_i && pend_found;

   assign we_o    = a_is_write;
   assign addr_o  = {tl_i.a_address[AW-1:2], 2'b00};
   assign wdata_o = tl_i.a_data;
   assign be_o    = tl_i.a_mask;

   assign unused_tl = ^{tl_i.a_param, tl_i.a_address};

   // The oldest occupied slot still waiting on the device; local errors are born done and are skipped.
   always_comb begin
      pend_found = 1'b0;
      pend_idx   = rd_ptr;
      scan_idx   = rd_ptr;
      for (int i = 0; i < Outstanding; i++) begin
         if (!pend_found && (CW'(i) < count) && !done_q[scan_idx]) begin
            pend_found = 1'b1;
            pend_idx   = scan_idx;
         end
         scan_idx = next_ptr(scan_idx);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < Outstanding; i++) begin
            is_read_q[i]   <= 1'b0;
            size_q[i]      <= '0;
            source_q[i]    <= '0;
            local_err_q[i] <= 1'b0;
            done_q[i]      <= 1'b0;
            data_q[i]      <= '0;
            err_q[i]       <= 1'b0;
         end
      end else begin
         if (push) begin
            is_read_q[wr_ptr]   <= !a_is_write;
            size_q[wr_ptr]      <= tl_i.a_size;
            source_q[wr_ptr]    <= tl_i.a_source;
            local_err_q[wr_ptr] <= a_local_err;
            done_q[wr_ptr]      <= a_local_err;
            data_q[wr_ptr]      <= '0;
            err_q[wr_ptr]       <= 1'b0;
            wr_ptr              <= next_ptr(wr_ptr);
         end
         if (complete) begin
            done_q[pend_idx] <= 1'b1;
            data_q[pend_idx] <= is_read_q[pend_idx] ? rdata_i : 32'h0;
            err_q[pend_idx]  <= err_i;
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (!push && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   assign head_err = err_q[rd_ptr] || local_err_q[rd_ptr];

   always_comb begin
      tl_o         = '0;
      tl_o.a_ready = a_ready;
      tl_o.d_valid = d_valid;
      if (d_valid) begin
         tl_o.d_opcode = is_read_q[rd_ptr] ? OP_ACK_DATA : OP_ACK;
         tl_o.d_size   = size_q[rd_ptr];
         tl_o.d_source = source_q[rd_ptr];
         tl_o.d_error  = head_err;
         tl_o.d_data   = (head_err && is_read_q[rd_ptr]) ? 32'hFFFF_FFFF : data_q[rd_ptr];
      end
   end

endmodule

// File: tb/tb_tlul_dev_adapter.sv
// Bench for tlul_dev_adapter: directed scenarios plus randomized traffic against a response-queue model.
// Build with +define+TLUL_DEV_ERRCHK_EN to exercise the optional legality checks.
module tb_tlul_dev_adapter;
  import tlul_dev_pkg::*;

  localparam int AW = 32;
  localparam int OUTS = 2;
  localparam logic [2:0] GET = 3'd4;
  localparam logic [2:0] PUTF = 3'd0;
  localparam logic [2:0] PUTP = 3'd1;

  logic clk = 1'b0;
  logic rst;
  tl_h2d_t a_side;
  logic d_ready;
  tl_h2d_t tl_i;
  tl_d2h_t tl_o;
  logic req, gnt, we, rvalid, err;
  logic [AW-1:0] addr;
  logic [31:0] wdata, rdata;
  logic [3:0] be;

  always #5 clk = ~clk;

  always_comb begin
    tl_i = a_side;
    tl_i.d_ready = d_ready;
  end

  tlul_dev_adapter #(.AW(AW), .Outstanding(OUTS)) dut (
    .clk_i(clk), .rst_i(rst), .tl_i(tl_i), .tl_o(tl_o),
    .req_o(req), .gnt_i(gnt), .we_o(we), .addr_o(addr), .wdata_o(wdata), .be_o(be),
    .rvalid_i(rvalid), .rdata_i(rdata), .err_i(err)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_grants = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected D beat {opcode, size, source, error, data}, in A acceptance order.
  logic [45:0] exp_q[$];
  int dev_due[$];
  logic [31:0] dev_rdata[$];
  bit dev_err[$];

  int gnt_prob = 100, dready_prob = 100, dly_min = 1, dly_max = 1, err_mode = 0;
  bit force_rdata = 0;
  logic [31:0] forced_rdata = '0;

  logic [2:0] cur_op;
  logic [1:0] cur_size;
  logic [7:0] cur_src;
  logic [31:0] cur_addr, cur_data;
  logic [3:0] cur_mask;
  bit cur_local;

  function automatic bit model_local_err(input logic [2:0] op, input logic [1:0] size,
                                         input logic [31:0] address, input logic [3:0] mask);
    int bytes;
    int first;
    logic [3:0] allowed;
    bit chk;
    bytes = 1 << size;
    first = (int'(address[1:0]) / bytes) * bytes;
    allowed = 4'(((1 << bytes) - 1) << first);
    chk = (address[1:0] != 2'b00) || (size > 2'd2) || (op == PUTF && mask != 4'hF)
          || ((mask & ~allowed) != 4'h0);
    if (op != PUTF && op != PUTP && op != GET) return 1'b1;
`ifdef TLUL_DEV_ERRCHK_EN
    if (chk) return 1'b1;
`else
    if (chk && 1'b0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [45:0] model_resp(input logic [2:0] op, input logic [1:0] size,
                                             input logic [7:0] src, input bit local_e,
                                             input bit dev_e, input logic [31:0] dev_data);
    bit is_write;
    bit e;
    logic [31:0] d;
    is_write = (op == PUTF) || (op == PUTP);
    e = local_e || dev_e;
    if (is_write) d = 32'h0;
    else if (e) d = 32'hFFFF_FFFF;
    else d = dev_data;
    return {(is_write ? 3'd0 : 3'd1), size, src, e, d};
  endfunction

  // Device: random gnt, in-order rvalid after a random delay, random d_ready.
  initial begin
    gnt = 0; rvalid = 0; rdata = '0; err = 0; d_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      err = 1'b0;
      rdata = $urandom;
      if (dev_due.size() > 0 && cyc >= dev_due[0]) begin
        rvalid = 1'b1;
        rdata = dev_rdata.pop_front();
        err = dev_err.pop_front();
        void'(dev_due.pop_front());
      end
      gnt = ($urandom_range(1, 100) <= gnt_prob);
      d_ready = ($urandom_range(1, 100) <= dready_prob);
    end
  end

  always @(negedge clk) begin
    logic [31:0] rv;
    bit ev;
    if (!rst && req) begin
      n_checks++;
      if (cur_local) begin
        n_fail++;
        $display("FAIL illegal_forwarded: req_o=1 op=%0d addr=%h", cur_op, cur_addr);
      end
    end
    if (!rst && req && gnt) begin
      n_grants++;
      n_checks += 4;
      if (addr !== (cur_addr & 32'hFFFF_FFFC)) begin
        n_fail++; $display("FAIL addr_o: got %h expected %h", addr, cur_addr & 32'hFFFF_FFFC);
      end
      if (we !== (cur_op != GET)) begin
        n_fail++; $display("FAIL we_o: got %b expected %b", we, cur_op != GET);
      end
      if (wdata !== cur_data) begin
        n_fail++; $display("FAIL wdata_o: got %h expected %h", wdata, cur_data);
      end
      if (be !== cur_mask) begin
        n_fail++; $display("FAIL be_o: got %h expected %h", be, cur_mask);
      end
      rv = force_rdata ? forced_rdata : $urandom;
      ev = (err_mode == 1) || (err_mode == 2 && $urandom_range(0, 3) == 0);
      dev_due.push_back(cyc + $urandom_range(dly_min, dly_max));
      dev_rdata.push_back(rv);
      dev_err.push_back(ev);
      exp_q.push_back(model_resp(cur_op, cur_size, cur_src, 1'b0, ev, rv));
    end
  end

  // D-channel monitor: in-order comparison on pop, and hold-while-stalled check.
  logic [46:0] last_d;
  bit prev_stall = 0;
  always @(negedge clk) begin
    logic [46:0] now_d;
    logic [45:0] e;
    now_d = {tl_o.d_valid, tl_o.d_opcode, tl_o.d_size, tl_o.d_source, tl_o.d_error, tl_o.d_data};
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (now_d !== last_d) begin
          n_fail++; $display("FAIL d_stable: got %h expected %h", now_d, last_d);
        end
      end
      if (tl_o.d_valid && d_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL d_unexpected: got d_valid=1 expected no response (src %h)", tl_o.d_source);
        end else begin
          e = exp_q.pop_front();
          n_checks += 4;
          if (tl_o.d_opcode !== e[45:43]) begin
            n_fail++; $display("FAIL d_opcode: got %0d expected %0d", tl_o.d_opcode, e[45:43]);
          end
          if ({tl_o.d_size, tl_o.d_source} !== e[42:33]) begin
            n_fail++; $display("FAIL d_size_source: got %h expected %h", {tl_o.d_size, tl_o.d_source}, e[42:33]);
          end
          if (tl_o.d_error !== e[32]) begin
            n_fail++; $display("FAIL d_error: got %b expected %b", tl_o.d_error, e[32]);
          end
          if (tl_o.d_data !== e[31:0]) begin
            n_fail++; $display("FAIL d_data: got %h expected %h", tl_o.d_data, e[31:0]);
          end
        end
      end
      prev_stall = tl_o.d_valid && !d_ready;
      last_d = now_d;
    end
  end

  task automatic drive_a(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                         input logic [31:0] address, input logic [3:0] mask, input logic [31:0] data);
    cur_op = op; cur_size = size; cur_src = src; cur_addr = address; cur_mask = mask; cur_data = data;
    cur_local = model_local_err(op, size, address, mask);
    a_side.a_opcode = op;
    a_side.a_param = 3'd0;
    a_side.a_size = size;
    a_side.a_source = src;
    a_side.a_address = address;
    a_side.a_mask = mask;
    a_side.a_data = data;
    a_side.a_valid = 1'b1;
  endtask

  task automatic wait_accept(input int budget);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!rst && tl_o.a_ready) begin
        if (cur_local) exp_q.push_back(model_resp(cur_op, cur_size, cur_src, 1'b1, 1'b0, 32'h0));
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++; $display("FAIL a_accept_timeout: got no a_ready expected accept within %0d cycles", budget);
    end
    @(posedge clk);
    #1;
    a_side.a_valid = 1'b0;
  endtask

  task automatic send_a(input logic [2:0] op, input logic [1:0] size, input logic [7:0] src,
                        input logic [31:0] address, input logic [3:0] mask, input logic [31:0] data);
    drive_a(op, size, src, address, mask, data);
    wait_accept(200);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && dev_due.size() == 0) break;
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (exp_q.size() != 0 || dev_due.size() != 0) begin
      n_fail++; $display("FAIL drain: got %0d responses pending expected 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic measure_dvalid(input int expected, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tl_o.d_valid && n < 20);
    n_checks++;
    if (n != expected) begin
      n_fail++; $display("FAIL %s: got %0d cycles expected %0d", name, n, expected);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(GET, 2'd2, 8'h11, 32'h10, 4'hF, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks += 2;
    if (tl_o !== '0) begin
      n_fail++; $display("FAIL reset_tl_o: got %h expected 0", tl_o);
    end
    if (req !== 1'b0) begin
      n_fail++; $display("FAIL reset_req: got %b expected 0", req);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_side = '0;
    @(negedge clk);
    n_checks += 2;
    if (tl_o.d_valid !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_dvalid: got %b expected 0", tl_o.d_valid);
    end
    if (req !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_req: got %b expected 0", req);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_get_basic();
    dly_min = 2; dly_max = 2; force_rdata = 1; forced_rdata = 32'hDEAD_BEEF;
    send_a(GET, 2'd2, 8'h5A, 32'h10, 4'hF, 32'h1234_5678);
    measure_dvalid(3, "get_latency");
    wait_drain(50);
    force_rdata = 0; dly_min = 1; dly_max = 1;
  endtask

  task automatic test_put_err();
    err_mode = 1;
    send_a(PUTF, 2'd2, 8'h21, 32'h4, 4'hF, 32'h55);
    wait_drain(50);
    err_mode = 0;
  endtask

  task automatic test_full();
    dready_prob = 0;
    send_a(GET, 2'd2, 8'h01, 32'h20, 4'hF, 32'h0);
    send_a(GET, 2'd2, 8'h02, 32'h24, 4'hF, 32'h0);
    drive_a(GET, 2'd2, 8'h03, 32'h28, 4'hF, 32'h0);
    repeat (4) begin
      @(negedge clk);
      n_checks += 2;
      if (tl_o.a_ready !== 1'b0) begin
        n_fail++; $display("FAIL full_a_ready: got %b expected 0", tl_o.a_ready);
      end
      if (req !== 1'b0) begin
        n_fail++; $display("FAIL full_req: got %b expected 0", req);
      end
    end
    dready_prob = 100;
    wait_accept(50);
    wait_drain(50);
  endtask

  task automatic test_illegal_opcode();
    dly_min = 1; dly_max = 3;
    send_a(GET, 2'd2, 8'h31, 32'h30, 4'hF, 32'h0);
    send_a(3'd3, 2'd2, 8'h32, 32'h34, 4'hF, 32'h0);
    send_a(GET, 2'd2, 8'h33, 32'h38, 4'hF, 32'h0);
    wait_drain(100);
    send_a(3'd3, 2'd1, 8'h34, 32'h3C, 4'h3, 32'h0);
    measure_dvalid(1, "local_err_latency");
    wait_drain(50);
    dly_min = 1; dly_max = 1;
  endtask

  task automatic test_errchk_addr();
    int g0;
    g0 = n_grants;
    send_a(GET, 2'd2, 8'h41, 32'h6, 4'hF, 32'h0);
    wait_drain(50);
    n_checks++;
`ifdef TLUL_DEV_ERRCHK_EN
    if (n_grants != g0) begin
      n_fail++; $display("FAIL errchk_grants: got %0d expected %0d", n_grants, g0);
    end
`else
    if (n_grants != g0 + 1) begin
      n_fail++; $display("FAIL errchk_grants: got %0d expected %0d", n_grants, g0 + 1);
    end
`endif
  endtask

  task automatic test_reset_midflight();
    bit saw;
    dly_min = 6; dly_max = 6;
    send_a(GET, 2'd2, 8'h51, 32'h40, 4'hF, 32'h0);
    send_a(GET, 2'd2, 8'h52, 32'h44, 4'hF, 32'h0);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    n_checks++;
    if (tl_o.a_ready !== 1'b0 || tl_o.d_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got a_ready=%b d_valid=%b expected 0 0", tl_o.a_ready, tl_o.d_valid);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (tl_o.d_valid) saw = 1;
    end
    n_checks++;
    if (saw) begin
      n_fail++; $display("FAIL dropped_response: got d_valid=1 expected 0 after reset");
    end
    @(posedge clk);
    #1;
    dly_min = 1; dly_max = 2;
    send_a(GET, 2'd2, 8'h53, 32'h48, 4'hF, 32'h0);
    wait_drain(50);
    dly_min = 1; dly_max = 1;
  endtask

  task automatic test_random();
    int r;
    logic [2:0] op;
    gnt_prob = 60; dready_prob = 70; dly_min = 1; dly_max = 4; err_mode = 2;
    for (int t = 0; t < 80; t++) begin
      r = $urandom_range(0, 9);
      if (r < 4) op = GET;
      else if (r < 6) op = PUTF;
      else if (r < 8) op = PUTP;
      else op = 3'($urandom_range(0, 7));
      send_a(op, 2'($urandom_range(0, 3)), 8'($urandom), $urandom & 32'h0000_FFFF,
             4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain(2000);
    gnt_prob = 100; dready_prob = 100; dly_min = 1; dly_max = 1; err_mode = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    a_side = '0;
    rst = 1'b1;
    test_reset();
    test_get_basic();
    test_put_err();
    test_full();
    test_illegal_opcode();
    test_errchk_addr();
    test_reset_midflight();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
